// File: rtl/rom_arbiter.sv
// rom_arbiter: two-requester arbiter in front of a shared, pipelined image ROM.
// Requests are masked for one cycle after a grant so that a requester holding
// req continuously gets at most every second slot. Contention goes to the
// requester that was not granted most recently. A tag pipeline follows each
// issued access through the ROM latency and routes the returned data to the
// right requester, in issue order.
module rom_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 12,
  parameter int ROM_LAT = 1
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  // Requester id of the most recent grant; reset to 1 so requester 0 wins
  // the first contention.
  logic last_grant;

  // Stage k holds the access issued k edges ago. Stage ROM_LAT lines up with
  // the cycle in which rom_data is valid for that access.
  logic [ROM_LAT:0] tag_valid;
  logic [ROM_LAT:0] tag_id;

  logic              mask0;
  logic              mask1;
  logic              issue;
  logic              win_id;
  logic [ADDR_W-1:0] win_addr;

  // Masked requests and winner selection for the current cycle.
  always_comb begin
    mask0    = req0 & ~gnt0;
    mask1    = req1 & ~gnt1;
    issue    = mask0 | mask1;
    win_id   = 1'b0;
    win_addr = addr0;
    if (mask0 && mask1) begin
      win_id = ~last_grant;
    end else if (mask1) begin
      win_id = 1'b1;
    end
    if (win_id) begin
      win_addr = addr1;
    end
  end

  // Grant pulses, registered ROM address and last-grant history.
  always_ff @(posedge pclk) begin
    if (rst) begin
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rom_addr   <= '0;
      last_grant <= 1'b1;
    end else begin
      gnt0 <= issue & ~win_id;
      gnt1 <= issue & win_id;
      if (issue) begin
        rom_addr   <= win_addr;
        last_grant <= win_id;
      end
    end
  end

  // Tag pipeline shifting one stage per edge; reset drops in-flight accesses.
  always_ff @(posedge pclk) begin
    if (rst) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      tag_valid <= {tag_valid[ROM_LAT-1:0], issue};
      tag_id    <= {tag_id[ROM_LAT-1:0], win_id};
    end
  end

  // Capture returning ROM data into the owning requester's output register.
  always_ff @(posedge pclk) begin
    if (rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= tag_valid[ROM_LAT] & ~tag_id[ROM_LAT];
      rvalid1 <= tag_valid[ROM_LAT] & tag_id[ROM_LAT];
      if (tag_valid[ROM_LAT] && !tag_id[ROM_LAT]) begin
        rdata0 <= rom_data;
      end
      if (tag_valid[ROM_LAT] && tag_id[ROM_LAT]) begin
        rdata1 <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed test of rom_arbiter with ROM_LAT=1 and ROM_LAT=3
// instances driven by the same requesters, each with its own ROM model.
module tb_rom_arbiter;

  logic        pclk = 1'b0;
  logic        rst;
  logic        req0;
  logic [11:0] addr0;
  logic        req1;
  logic [11:0] addr1;

  logic        gnt0_l1, gnt1_l1, rvalid0_l1, rvalid1_l1;
  logic [11:0] rdata0_l1, rdata1_l1, rom_addr_l1;
  logic [11:0] rom_data_l1;

  logic        gnt0_l3, gnt1_l3, rvalid0_l3, rvalid1_l3;
  logic [11:0] rdata0_l3, rdata1_l3, rom_addr_l3;
  logic [11:0] rom_pipe_l3 [3];

  int eval_count = 0;
  int fail_count = 0;
  int rv0_count;
  int rv1_count;

  // Free-running pixel clock.
  always #5 pclk = ~pclk;

  // ROM contents model: a fixed scramble of the address.
  function automatic logic [11:0] rom_fn(input logic [11:0] a);
    return a ^ 12'hA5A;
  endfunction

  // Single-cycle ROM model for the ROM_LAT=1 instance.
  always @(posedge pclk) rom_data_l1 <= rom_fn(rom_addr_l1);

  // Three-cycle ROM model for the ROM_LAT=3 instance.
  always @(posedge pclk) begin
    rom_pipe_l3[0] <= rom_fn(rom_addr_l3);
    rom_pipe_l3[1] <= rom_pipe_l3[0];
    rom_pipe_l3[2] <= rom_pipe_l3[1];
  end

  rom_arbiter #(.ADDR_W(12), .DATA_W(12), .ROM_LAT(1)) u_lat1 (
    .pclk(pclk), .rst(rst),
    .req0(req0), .addr0(addr0), .gnt0(gnt0_l1), .rdata0(rdata0_l1), .rvalid0(rvalid0_l1),
    .req1(req1), .addr1(addr1), .gnt1(gnt1_l1), .rdata1(rdata1_l1), .rvalid1(rvalid1_l1),
    .rom_addr(rom_addr_l1), .rom_data(rom_data_l1)
  );

  rom_arbiter #(.ADDR_W(12), .DATA_W(12), .ROM_LAT(3)) u_lat3 (
    .pclk(pclk), .rst(rst),
    .req0(req0), .addr0(addr0), .gnt0(gnt0_l3), .rdata0(rdata0_l3), .rvalid0(rvalid0_l3),
    .req1(req1), .addr1(addr1), .gnt1(gnt1_l3), .rdata1(rdata1_l3), .rvalid1(rvalid1_l3),
    .rom_addr(rom_addr_l3), .rom_data(rom_pipe_l3[2])
  );

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    eval_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive all requester-side inputs at once.
  task automatic applyStimulus(input logic r, input logic q0, input logic [11:0] a0,
                               input logic q1, input logic [11:0] a1);
    rst   = r;
    req0  = q0;
    addr0 = a0;
    req1  = q1;
    addr1 = a1;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Hold reset for two edges and verify every output is cleared.
  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 12'h000, 1'b0, 12'h000);
    tick();
    tick();
    checkOutput("rst_gnt0",     gnt0_l1,     0);
    checkOutput("rst_gnt1",     gnt1_l1,     0);
    checkOutput("rst_rvalid0",  rvalid0_l1,  0);
    checkOutput("rst_rvalid1",  rvalid1_l1,  0);
    checkOutput("rst_rdata0",   rdata0_l1,   0);
    checkOutput("rst_rdata1",   rdata1_l1,   0);
    checkOutput("rst_rom_addr", rom_addr_l1, 0);
    checkOutput("rst_l3_rvalid", {rvalid0_l3, rvalid1_l3}, 0);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 12'h000, 1'b0, 12'h000);

    // Single request from requester 0, ROM_LAT=1.
    $display("[TB] single access");
    doReset();
    applyStimulus(1'b0, 1'b1, 12'h123, 1'b0, 12'h000);
    tick();
    checkOutput("single_gnt0", gnt0_l1, 1);
    checkOutput("single_gnt1", gnt1_l1, 0);
    checkOutput("single_rom_addr", rom_addr_l1, 12'h123);
    applyStimulus(1'b0, 1'b0, 12'h000, 1'b0, 12'h000);
    tick();
    checkOutput("single_gnt0_drop", gnt0_l1, 0);
    checkOutput("single_rvalid0_early", rvalid0_l1, 0);
    tick();
    checkOutput("single_rvalid0", rvalid0_l1, 1);
    checkOutput("single_rdata0", rdata0_l1, rom_fn(12'h123));
    checkOutput("single_rvalid1", rvalid1_l1, 0);
    tick();
    checkOutput("single_rvalid0_pulse", rvalid0_l1, 0);
    checkOutput("single_rdata0_hold", rdata0_l1, rom_fn(12'h123));
    checkOutput("single_rvalid1_late", rvalid1_l1, 0);

    // Both requesters held: grants alternate, responses follow two edges later.
    $display("[TB] continuous contention");
    doReset();
    applyStimulus(1'b0, 1'b1, 12'h010, 1'b1, 12'h020);
    for (int k = 1; k <= 6; k++) begin
      tick();
      checkOutput($sformatf("alt_gnt0_%0d", k), gnt0_l1, (k % 2 == 1));
      checkOutput($sformatf("alt_gnt1_%0d", k), gnt1_l1, (k % 2 == 0));
      checkOutput($sformatf("alt_addr_%0d", k), rom_addr_l1,
                  (k % 2 == 1) ? 12'h010 : 12'h020);
      checkOutput($sformatf("alt_l3_gnt0_%0d", k), gnt0_l3, (k % 2 == 1));
      checkOutput($sformatf("alt_rvalid0_%0d", k), rvalid0_l1, (k >= 3) && (k % 2 == 1));
      checkOutput($sformatf("alt_rvalid1_%0d", k), rvalid1_l1, (k >= 3) && (k % 2 == 0));
      if (k >= 3 && k % 2 == 1) checkOutput($sformatf("alt_rdata0_%0d", k), rdata0_l1, rom_fn(12'h010));
      if (k >= 3 && k % 2 == 0) checkOutput($sformatf("alt_rdata1_%0d", k), rdata1_l1, rom_fn(12'h020));
    end

    // Requester 1 alone for 6 cycles: grants on cycles 1,3,5 only.
    $display("[TB] lone requester 1");
    doReset();
    rv0_count = 0;
    rv1_count = 0;
    applyStimulus(1'b0, 1'b0, 12'h000, 1'b1, 12'h0F0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 6) applyStimulus(1'b0, 1'b0, 12'h000, 1'b0, 12'h0F0);
      if (k <= 6) begin
        checkOutput($sformatf("lone_gnt1_%0d", k), gnt1_l1, (k % 2 == 1));
        checkOutput($sformatf("lone_gnt0_%0d", k), gnt0_l1, 0);
      end
      if (rvalid1_l1) checkOutput($sformatf("lone_rdata1_%0d", k), rdata1_l1, rom_fn(12'h0F0));
      rv0_count += int'(rvalid0_l1);
      rv1_count += int'(rvalid1_l1);
    end
    checkOutput("lone_rvalid1_count", rv1_count, 3);
    checkOutput("lone_rvalid0_count", rv0_count, 0);

    // Last grant persists across idle: after a requester 0 grant, contention goes to 1.
    $display("[TB] last grant history");
    doReset();
    applyStimulus(1'b0, 1'b1, 12'h111, 1'b0, 12'h222);
    tick();
    checkOutput("hist_first_gnt0", gnt0_l1, 1);
    applyStimulus(1'b0, 1'b0, 12'h111, 1'b0, 12'h222);
    tick();
    tick();
    applyStimulus(1'b0, 1'b1, 12'h111, 1'b1, 12'h222);
    tick();
    checkOutput("hist_contend_gnt1", gnt1_l1, 1);
    checkOutput("hist_contend_gnt0", gnt0_l1, 0);
    checkOutput("hist_contend_addr", rom_addr_l1, 12'h222);
    applyStimulus(1'b0, 1'b0, 12'h000, 1'b0, 12'h000);
    tick();

    // Reset right after a grant discards the in-flight access.
    $display("[TB] reset mid-flight");
    doReset();
    applyStimulus(1'b0, 1'b1, 12'h0AA, 1'b0, 12'h000);
    tick();
    checkOutput("flush_gnt0", gnt0_l1, 1);
    applyStimulus(1'b1, 1'b0, 12'h000, 1'b0, 12'h000);
    tick();
    checkOutput("flush_gnt0_rst", gnt0_l1, 0);
    checkOutput("flush_rom_addr_rst", rom_addr_l1, 0);
    checkOutput("flush_rvalid0_rst", rvalid0_l1, 0);
    checkOutput("flush_rdata0_rst", rdata0_l1, 0);
    applyStimulus(1'b0, 1'b0, 12'h000, 1'b0, 12'h000);
    rv0_count = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      rv0_count += int'(rvalid0_l1) + int'(rvalid0_l3);
    end
    checkOutput("flush_rvalid0_count", rv0_count, 0);

    // ROM_LAT=3: alternating accesses return 4 edges after their grant, in order.
    $display("[TB] ROM_LAT=3 ordering");
    doReset();
    applyStimulus(1'b0, 1'b1, 12'h001, 1'b1, 12'h002);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) applyStimulus(1'b0, 1'b1, 12'h003, 1'b1, 12'h002);
      if (k == 2) applyStimulus(1'b0, 1'b1, 12'h003, 1'b0, 12'h000);
      if (k == 3) applyStimulus(1'b0, 1'b0, 12'h000, 1'b0, 12'h000);
      if (k <= 3) checkOutput($sformatf("lat3_gnt1_%0d", k), gnt1_l3, (k == 2));
      if (k == 3) checkOutput("lat3_addr_3", rom_addr_l3, 12'h003);
      checkOutput($sformatf("lat3_rvalid0_%0d", k), rvalid0_l3, (k == 5) || (k == 7));
      checkOutput($sformatf("lat3_rvalid1_%0d", k), rvalid1_l3, (k == 6));
      if (k == 5) checkOutput("lat3_rdata0_a", rdata0_l3, rom_fn(12'h001));
      if (k == 6) checkOutput("lat3_rdata1", rdata1_l3, rom_fn(12'h002));
      if (k == 7) checkOutput("lat3_rdata0_b", rdata0_l3, rom_fn(12'h003));
    end

    // One access then 10 idle cycles: address holds, nothing else happens.
    $display("[TB] idle hold");
    doReset();
    applyStimulus(1'b0, 1'b1, 12'h055, 1'b0, 12'h000);
    tick();
    checkOutput("idle_gnt0", gnt0_l1, 1);
    applyStimulus(1'b0, 1'b0, 12'h000, 1'b0, 12'h000);
    tick();
    tick();
    checkOutput("idle_resp", rvalid0_l1, 1);
    rv0_count = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checkOutput($sformatf("idle_addr_%0d", k), rom_addr_l1, 12'h055);
      checkOutput($sformatf("idle_gnt_%0d", k), {gnt0_l1, gnt1_l1}, 0);
      rv0_count += int'(rvalid0_l1) + int'(rvalid1_l1);
    end
    checkOutput("idle_rvalid_count", rv0_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", eval_count, fail_count);
    $finish;
  end

endmodule
